icache_ctrl: RTL

ICACHE_CTRL -- requirements
Module: icache_ctrl

---
 rtl/icache_ctrl_if.sv | 33 +++
 rtl/icache_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/icache_ctrl_if.sv
// Fetch-side and memory-side signal bundle of the instruction cache controller.
interface icache_ctrl_if;
  logic [11:0] icache_idx;
  logic [2:0]  icache_op;
  logic [31:0] icache_pa;
  logic        icache_is_cached;
  logic        icache_ready;
  logic [31:0] icache_data;
  logic        icache_data_valid;
  logic        icache_data_ready;
  logic        cancel;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [1:0]  mem_len;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_rlast;

  // Controller view
  modport slave (
    input  icache_idx, icache_op, icache_pa, icache_is_cached, icache_data_ready, cancel,
    input  mem_gnt, mem_rvalid, mem_rdata, mem_rlast,
    output icache_ready, icache_data, icache_data_valid, mem_req, mem_addr, mem_len
  );

  // Fetch unit plus memory side view
  modport master (
    output icache_idx, icache_op, icache_pa, icache_is_cached, icache_data_ready, cancel,
    output mem_gnt, mem_rvalid, mem_rdata, mem_rlast,
    input  icache_ready, icache_data, icache_data_valid, mem_req, mem_addr, mem_len
  );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped 4 KiB instruction cache controller (256 lines x 16 B) with cacop support.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STAT_EN.
module icache_ctrl (
  input  logic          clk,
  input  logic          rst,
  icache_ctrl_if.slave  bus
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0]   hit_cnt,
  output logic [31:0]   miss_cnt
`endif
);

  localparam int unsigned LINES  = 256;
  localparam int unsigned WORDS  = 4;
  localparam int unsigned LINE_W = 8;
  localparam int unsigned WORD_W = 2;
  localparam int unsigned TAG_W  = 20;
  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] OP_FETCH    = 3'd1;
  localparam logic [2:0] OP_IDX_INIT = 3'd2;
  localparam logic [2:0] OP_IDX_INV  = 3'd3;
  localparam logic [2:0] OP_HIT_INV  = 3'd4;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MISS, S_REFILL, S_RESP} state_t;

  state_t state, state_nxt;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES*WORDS];

  logic [LINE_W-1:0] line_q;
  logic [31:0]       pa_q;
  logic              cached_q;
  logic              valid_rd_q;
  logic [TAG_W-1:0]  tag_rd_q;
  logic [DATA_W-1:0] data_rd_q;
  logic [DATA_W-1:0] resp_q;
  logic [WORD_W-1:0] beat_q;
  logic              drop_q;

  logic              hit;
  logic              ready_c;
  logic              valid_c;
  logic              mem_req_c;
  logic              accept_fetch;
  logic              accept_cacop;
  logic              refill_beat;
  logic              refill_done;
  logic [LINE_W-1:0] req_line;
  logic              unused_idx_lsb;

  assign req_line       = bus.icache_idx[11:4];
  assign unused_idx_lsb = ^bus.icache_idx[1:0];

  assign hit         = cached_q && valid_rd_q && (tag_rd_q == pa_q[31:12]);
  assign refill_beat = (state == S_REFILL) && bus.mem_rvalid;
  assign refill_done = refill_beat && bus.mem_rlast;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake decode
  always_comb begin
    state_nxt    = state;
    ready_c      = 1'b0;
    valid_c      = 1'b0;
    mem_req_c    = 1'b0;
    accept_fetch = 1'b0;
    accept_cacop = 1'b0;
    case (state)
      S_IDLE: begin
        ready_c = 1'b1;
        if (bus.icache_op == OP_FETCH) state_nxt = S_LOOKUP;
      end
      S_LOOKUP: begin
        valid_c = hit;
        if (bus.cancel) begin
          state_nxt = S_IDLE;
        end else if (hit) begin
          if (bus.icache_data_ready) begin
            ready_c   = 1'b1;
            state_nxt = (bus.icache_op == OP_FETCH) ? S_LOOKUP : S_IDLE;
          end else begin
            state_nxt = S_RESP;
          end
        end else begin
          state_nxt = S_MISS;
        end
      end
      S_MISS: begin
        mem_req_c = 1'b1;
        if (bus.mem_gnt) state_nxt = S_REFILL;
      end
      S_REFILL: begin
        // A cancelled refill still runs to completion so the line is left consistent
        if (refill_done) state_nxt = (drop_q || bus.cancel) ? S_IDLE : S_RESP;
      end
      S_RESP: begin
        valid_c = 1'b1;
        if (bus.cancel || bus.icache_data_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    accept_fetch = ready_c && (bus.icache_op == OP_FETCH);
    accept_cacop = ready_c && (bus.icache_op inside {OP_IDX_INIT, OP_IDX_INV, OP_HIT_INV});
  end

  assign bus.icache_ready      = ready_c;
  assign bus.icache_data_valid = valid_c;
  assign bus.icache_data       = (state == S_RESP) ? resp_q : data_rd_q;
  assign bus.mem_req           = mem_req_c;
  assign bus.mem_addr          = cached_q ? {pa_q[31:4], 4'b0000} : pa_q;
  assign bus.mem_len           = cached_q ? 2'd3 : 2'd0;

  // Request capture, array read port and response word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q     <= '0;
      pa_q       <= '0;
      cached_q   <= 1'b0;
      valid_rd_q <= 1'b0;
      tag_rd_q   <= '0;
      data_rd_q  <= '0;
      resp_q     <= '0;
      beat_q     <= '0;
      drop_q     <= 1'b0;
    end else begin
      if (accept_fetch) begin
        line_q     <= req_line;
        pa_q       <= bus.icache_pa;
        cached_q   <= bus.icache_is_cached;
        valid_rd_q <= valid_q[req_line];
        tag_rd_q   <= tag_mem[req_line];
        data_rd_q  <= data_mem[bus.icache_idx[11:2]];
      end
      if ((state == S_LOOKUP) && hit && !bus.icache_data_ready) resp_q <= data_rd_q;
      if ((state == S_MISS) && bus.mem_gnt) beat_q <= '0;
      if (refill_beat) begin
        beat_q <= beat_q + 2'd1;
        if (!cached_q || (beat_q == pa_q[3:2])) resp_q <= bus.mem_rdata;
      end
      if (state == S_LOOKUP) drop_q <= 1'b0;
      else if (((state == S_MISS) || (state == S_REFILL)) && bus.cancel) drop_q <= 1'b1;
    end
  end

  // Valid bits: the only array state cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      if (accept_cacop) begin
        case (bus.icache_op)
          OP_IDX_INIT, OP_IDX_INV: valid_q[req_line] <= 1'b0;
          OP_HIT_INV: if (tag_mem[req_line] == bus.icache_pa[31:12]) valid_q[req_line] <= 1'b0;
          default: ;
        endcase
      end
      if (refill_done && cached_q) valid_q[line_q] <= 1'b1;
    end
  end

  // Tag and data storage; uncached fetches never write here
  always_ff @(posedge clk) begin
    if (accept_cacop && (bus.icache_op == OP_IDX_INIT)) tag_mem[req_line] <= '0;
    if (refill_done && cached_q) tag_mem[line_q] <= pa_q[31:12];
    if (refill_beat && cached_q) data_mem[{line_q, beat_q}] <= bus.mem_rdata;
  end

`ifdef ICACHE_STAT_EN
  // Cached lookup outcome counters, free-running with natural wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if ((state == S_LOOKUP) && cached_q) begin
      if (hit) hit_cnt  <= hit_cnt + 32'd1;
      else     miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule
